// File: rtl/sort4_ctrl_pkg.sv
// sort4_ctrl_pkg: shared state encoding and sizing constants for the 4-element sorter.
package sort4_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int ELEM_W = 4;
   localparam int ELEM_N = 4;
   localparam logic [1:0] LAST_IDX = 2'd2;
   localparam logic [1:0] LAST_PASS = 2'd2;
endpackage

// File: rtl/sort4_ctrl_nibble_cmp.sv
// nibble_cmp: W-bit unsigned magnitude comparator.
module nibble_cmp
   import sort4_ctrl_pkg::*;
#(
   parameter int W = ELEM_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         eq,
   output logic         gt,
   output logic         sm
);
   assign eq = a == b;
   assign gt = a > b;
   assign sm = a < b;
endmodule

// File: rtl/sort4_ctrl.sv
// sort4_ctrl: bubble sort of four unsigned elements, one compare per cycle through a shared comparator.
module sort4_ctrl
   import sort4_ctrl_pkg::*;
#(
   parameter int W = ELEM_W,
   parameter int N = ELEM_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W*N-1:0] data_in,
   output logic           busy,
   output logic           done,
   output logic [W*N-1:0] data_out,
   output logic [3:0]     swap_cnt
);
   state_t state, state_nxt;
   logic [N-1:0][W-1:0] work, work_sw;
   logic [1:0] idx, idx_n, pass;
   logic pass_swap, eq, gt, sm, finish, unused_cmp;
   assign idx_n = idx + 2'd1;
   assign unused_cmp = eq | sm;
   nibble_cmp #(.W(W)) u_cmp (
      .a (work[idx]),
      .b (work[idx_n]),
      .eq(eq),
      .gt(gt),
      .sm(sm)
   );
   // Early exit once a whole pass saw no swap, counting this cycle's compare.
   assign finish = idx == LAST_IDX && (!(pass_swap || gt) || pass == LAST_PASS);
   always_comb begin
      work_sw = work;
      if (gt) begin
         work_sw[idx]   = work[idx_n];
         work_sw[idx_n] = work[idx];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = start ? RUN : IDLE;
         RUN:  state_nxt = finish ? DONE : RUN;
         default: state_nxt = IDLE;
      endcase
   end
   always_comb begin
      busy = state != IDLE;
      done = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         work      <= '0;
         idx       <= '0;
         pass      <= '0;
         pass_swap <= 1'b0;
         swap_cnt  <= '0;
         data_out  <= '0;
      end else if (state == IDLE && start) begin
         work      <= data_in;
         idx       <= '0;
         pass      <= '0;
         pass_swap <= 1'b0;
         swap_cnt  <= '0;
      end else if (state == RUN) begin
         work <= work_sw;
         if (gt) swap_cnt <= swap_cnt + 4'd1;
         if (idx == LAST_IDX) begin
            idx       <= '0;
            pass_swap <= 1'b0;
            if (!finish) pass <= pass + 2'd1;
         end else begin
            idx       <= idx_n;
            pass_swap <= pass_swap | gt;
         end
         if (finish) data_out <= work_sw;
      end
   end
endmodule

// File: tb/tb_sort4_ctrl.sv
// tb_sort4_ctrl: directed and random self-checking bench for sort4_ctrl.
module tb_sort4_ctrl;
   logic clk = 1'b0, rst, start, busy, done;
   logic [15:0] data_in, data_out;
   logic [3:0] swap_cnt;
   int vectors = 0, miscompares = 0;

   sort4_ctrl #(.W(4), .N(4)) dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in),
      .busy(busy), .done(done), .data_out(data_out), .swap_cnt(swap_cnt)
   );

   always #5 clk = ~clk;

   // Start one sort; optionally pulse start with 16'hAAAA on RUN cycle 'pulse'; el<0 skips latency check.
   task automatic sort_one(input logic [15:0] d, input logic [15:0] eo, input logic [3:0] ec,
                           input int el, input int pulse, input string nm);
      int lat;
      @(negedge clk);
      start = 1'b1;
      data_in = d;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         start = lat == pulse;
         if (start) data_in = 16'hAAAA;
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL %s timeout: done not seen after %0d cycles", nm, lat);
      end
      vectors++;
      if (el >= 0 && lat !== el) begin
         miscompares++;
         $display("FAIL %s latency: got %0d expected %0d", nm, lat, el);
      end
      vectors++;
      if (data_out !== eo) begin
         miscompares++;
         $display("FAIL %s data_out: got %h expected %h", nm, data_out, eo);
      end
      vectors++;
      if (swap_cnt !== ec) begin
         miscompares++;
         $display("FAIL %s swap_cnt: got %0d expected %0d", nm, swap_cnt, ec);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      data_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({busy, done, data_out, swap_cnt} !== 22'd0) begin
         miscompares++;
         $display("FAIL reset: busy=%b done=%b data_out=%h swap_cnt=%0d expected all zero",
                  busy, done, data_out, swap_cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      sort_one(16'h0123, 16'h3210, 4'd6, 10, 0, "reverse");
      sort_one(16'h3210, 16'h3210, 4'd0, 4, 0, "sorted");
      sort_one(16'hF0F0, 16'hFF00, 4'd1, 7, 0, "dup_f0f0");
      sort_one(16'h7777, 16'h7777, 4'd0, 4, 0, "dup_7777");
   endtask

   task automatic test_abort();
      int seen;
      @(negedge clk);
      start = 1'b1;
      data_in = 16'h0123;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (busy !== 1'b0 || data_out !== 16'h0 || swap_cnt !== 4'd0) begin
         miscompares++;
         $display("FAIL abort_state: busy=%b data_out=%h swap_cnt=%0d expected 0/0000/0",
                  busy, data_out, swap_cnt);
      end
      seen = 0;
      repeat (12) begin
         if (done) seen++;
         @(negedge clk);
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++;
         $display("FAIL abort_done: got %0d done pulses expected 0", seen);
      end
      sort_one(16'h1032, 16'h3210, 4'd4, -1, 0, "after_abort");
   endtask

   task automatic test_start_busy();
      sort_one(16'h0123, 16'h3210, 4'd6, 10, 3, "start_while_busy");
   endtask

   task automatic test_back_to_back();
      int g;
      @(negedge clk);
      start = 1'b1;
      data_in = 16'h3210;
      g = 0;
      while (!done && g < 20) begin
         @(negedge clk);
         g++;
      end
      repeat (2) begin
         g = 0;
         do begin
            @(negedge clk);
            g++;
            if (g == 1) begin
               vectors++;
               if (busy !== 1'b0) begin
                  miscompares++;
                  $display("FAIL b2b_idle: busy got %b expected 0", busy);
               end
            end
            if (g == 2) begin
               vectors++;
               if (busy !== 1'b1) begin
                  miscompares++;
                  $display("FAIL b2b_run: busy got %b expected 1", busy);
               end
            end
         end while (!done && g < 20);
         vectors++;
         if (g !== 5) begin
            miscompares++;
            $display("FAIL b2b_gap: done spacing got %0d expected 5", g);
         end
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random();
      logic [3:0] e[4];
      logic [3:0] t;
      logic [15:0] d, eo;
      logic [3:0] inv;
      for (int n = 0; n < 1000; n++) begin
         d = 16'($urandom);
         inv = '0;
         for (int i = 0; i < 4; i++) e[i] = d[i*4 +: 4];
         for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
               if (e[i] > e[j]) inv++;
         for (int i = 1; i < 4; i++)
            for (int j = i; j > 0 && e[j-1] > e[j]; j--) begin
               t = e[j];
               e[j] = e[j-1];
               e[j-1] = t;
            end
         eo = {e[3], e[2], e[1], e[0]};
         sort_one(d, eo, inv, -1, 0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_abort();
      test_start_busy();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
